// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter:
// response-owner encoding, default starvation bound and owner helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    localparam int unsigned MAX_DATA_RUN_DEF = 4;

    // Which requester the RAM response belongs to, given this cycle's grants.
    function automatic owner_e owner_of(input logic if_gnt, input logic dm_gnt);
        owner_e own;
        if (dm_gnt) begin
            own = OWN_DM;
        end else if (if_gnt) begin
            own = OWN_IF;
        end else begin
            own = OWN_NONE;
        end
        return own;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_run_counter.sv
// Anti-starvation counter: counts consecutive data grants while a fetch waits
// and forces the next grant to fetch once the bound is reached.
module arb_run_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_RUN = MAX_DATA_RUN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic if_gnt,
    input  logic dm_gnt,
    output logic force_fetch
);

    localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

    logic [3:0] run_cnt_r;
    logic [3:0] run_cnt_nxt_s;

    // Next count: clear when fetch is served or absent, saturate at the bound.
    always_comb begin
        run_cnt_nxt_s = run_cnt_r;
        if (if_gnt || !if_req) begin
            run_cnt_nxt_s = 4'd0;
        end else if (dm_gnt && (run_cnt_r < RUN_MAX)) begin
            run_cnt_nxt_s = run_cnt_r + 4'd1;
        end else begin
            run_cnt_nxt_s = run_cnt_r;
        end
    end

    // Run counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt_r <= 4'd0;
        end else begin
            run_cnt_r <= run_cnt_nxt_s;
        end
    end

    assign force_fetch = (run_cnt_r == RUN_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data
// memory; data wins unless it has starved fetch for MAX_DATA_RUN grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW           = 16,
    parameter int unsigned DW           = 16,
    parameter int unsigned MAX_DATA_RUN = MAX_DATA_RUN_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_stall,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_stall,
    output logic          dm_valid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic   force_fetch_s;
    logic   if_gnt_s;
    logic   dm_gnt_s;
    owner_e owner_r;
    logic   if_valid_r;
    logic   dm_valid_r;
    logic   dm_wr_r;

    arb_run_counter #(
        .MAX_DATA_RUN(MAX_DATA_RUN)
    ) u_run_counter (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_gnt     (if_gnt_s),
        .dm_gnt     (dm_gnt_s),
        .force_fetch(force_fetch_s)
    );

    // Grant decision; nothing is granted while reset is held.
    always_comb begin
        if_gnt_s = 1'b0;
        dm_gnt_s = 1'b0;
        if (!reset) begin
            if_gnt_s = 1'b0;
            dm_gnt_s = 1'b0;
        end else if (dm_req && !(if_req && force_fetch_s)) begin
            dm_gnt_s = 1'b1;
        end else if (if_req) begin
            if_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
            dm_gnt_s = 1'b0;
        end
    end

    assign if_gnt    = if_gnt_s;
    assign dm_gnt    = dm_gnt_s;
    assign if_stall  = if_req & ~if_gnt_s;
    assign dm_stall  = dm_req & ~dm_gnt_s;
    assign mem_en    = if_gnt_s | dm_gnt_s;
    assign mem_we    = dm_gnt_s & dm_we;
    assign mem_addr  = dm_gnt_s ? dm_addr : if_addr;
    assign mem_wdata = dm_gnt_s ? dm_wdata : {DW{1'b0}};

    // Response owner: remembers this cycle's grant to route next cycle's data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_r    <= OWN_NONE;
            if_valid_r <= 1'b0;
            dm_valid_r <= 1'b0;
            dm_wr_r    <= 1'b0;
        end else begin
            owner_r    <= owner_of(if_gnt_s, dm_gnt_s);
            if_valid_r <= if_gnt_s;
            dm_valid_r <= dm_gnt_s;
            dm_wr_r    <= dm_gnt_s & dm_we;
        end
    end

    assign if_valid = if_valid_r;
    assign dm_valid = dm_valid_r;

    // Route the RAM output to its owner; a write acknowledge carries zero data.
    always_comb begin
        if_rdata = {DW{1'b0}};
        dm_rdata = {DW{1'b0}};
        case (owner_r)
            OWN_IF: begin
                if_rdata = mem_rdata;
            end
            OWN_DM: begin
                dm_rdata = dm_wr_r ? {DW{1'b0}} : mem_rdata;
            end
            default: begin
                if_rdata = {DW{1'b0}};
                dm_rdata = {DW{1'b0}};
            end
        endcase
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the instruction-fetch stage and the data-memory stage of the 5-stage processor, so the core can run from a unified memory.
- Grants at most one access per cycle. Data has priority, bounded by an anti-starvation counter.
- Returns read data one cycle after the grant and tags it to the correct requester.
- Generates per-requester stall signals that feed the hazard logic.

Parameters:
- AW, 16, address width
- DW, 16, data width
- MAX_DATA_RUN, 4, maximum consecutive data grants while a fetch is pending (legal range 1..15)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- if_req  input  1  fetch request; held with if_addr stable until granted
- if_addr  input  AW  fetch address
- if_gnt  output  1  fetch granted this cycle
- if_stall  output  1  if_req and not if_gnt
- if_valid  output  1  if_rdata valid this cycle
- if_rdata  output  DW  fetched instruction
- dm_req  input  1  data request; held with addr/we/wdata stable until granted
- dm_we  input  1  1 = write, 0 = read
- dm_addr  input  AW  data address
- dm_wdata  input  DW  write data
- dm_gnt  output  1  data granted this cycle
- dm_stall  output  1  dm_req and not dm_gnt
- dm_valid  output  1  read data valid, or write acknowledged
- dm_rdata  output  DW  read data
- mem_en  output  1  RAM enable
- mem_we  output  1  RAM write enable
- mem_addr  output  AW  RAM address
- mem_wdata  output  DW  RAM write data
- mem_rdata  input  DW  RAM read data, valid the cycle after mem_en

Behaviour:
- Reset (reset=0, async) clears the following to 0: if_valid, dm_valid, owner register, run counter.
  - Combinational outputs follow the inputs even during reset, but grants are forced to 0 while reset=0.
- Grant decision, combinational each cycle:
  - Only dm_req: grant data.
  - Only if_req: grant fetch.
  - Both, and run_cnt < MAX_DATA_RUN: grant data.
  - Both, and run_cnt == MAX_DATA_RUN: grant fetch.
  - Neither: no grant, mem_en=0.
- RAM drive:
  - mem_en = if_gnt | dm_gnt.
  - mem_we = dm_gnt & dm_we.
  - mem_addr and mem_wdata are muxed from the granted requester.
  - mem_wdata = 0 when fetch is granted.
- run_cnt, 4 bits, registered:
  - Increments on a data grant while if_req=1, saturating at MAX_DATA_RUN.
  - Clears to 0 on any fetch grant, or on any cycle with if_req=0.
- Owner register, 2 states: NONE, IF, DM. It records this cycle's grant; next cycle it routes the response.
  - owner==IF: if_valid=1, if_rdata=mem_rdata.
  - owner==DM: dm_valid=1, dm_rdata=mem_rdata (for a write, dm_rdata=0).
  - Otherwise both valid=0 and both rdata hold 0.
- Latency: a grant in cycle N gives valid in cycle N+1. Back-to-back grants are legal every cycle, with full throughput.
- A request held across a stall is granted exactly once. The requester must drop or advance its req after a gnt cycle; the arbiter does not detect duplicates.
- Simultaneous dm write and fetch to the same address: resolved by priority. The later read sees the written value.
- Reset asserted mid-transaction: a pending valid is dropped (not delivered), and the counter clears.
- if_valid and dm_valid are never both 1 in the same cycle.

Decomposition:
- Shared package holds:
  - Owner encoding constants: OWN_NONE=2'd0, OWN_IF=2'd1, OWN_DM=2'd2.
  - Default MAX_DATA_RUN.
- One natural sub-module: arb_run_counter, the saturating starvation counter plus the force-fetch decision. Everything else stays in the top module.

Test Plan:
- Only if_req=1, addresses 0,1,2 on consecutive cycles, RAM preloaded 0xA000+addr -> if_gnt=1 every cycle, if_stall=0, if_valid=1 in cycles 2,3,4 with if_rdata 0xA000, 0xA001, 0xA002.
- dm write addr 0x0010 data 0x1234, then dm read 0x0010 next cycle -> mem_we=1 in cycle 1, dm_valid=1 in cycles 2 and 3, dm_rdata=0x1234 in cycle 3.
- if_req and dm_req both held high for 10 cycles with MAX_DATA_RUN=4 -> grant pattern D,D,D,D,I repeating, if_stall=1 on the D cycles, if_valid exactly 2 times.
- dm_req only for 6 cycles, no fetch -> run_cnt stays 0 and dm_gnt=1 every cycle.
- Read granted in cycle N, reset pulled low at N+0.5 for 1 cycle -> no valid in N+1, all registered outputs 0, and normal grants resume after release.
- Random req/addr stream over 2000 cycles against a scoreboard model -> every granted read returns model data to the correct port, and the if and dm valids are never simultaneous.
